// File: rtl/pipe_stage_reg_pkg.sv
// Shared constants and load-selection helper for the generic pipeline stage register.
// Stages pick their Tnew decrement from the STAGE_*_DEC values below.
package pipe_stage_reg_pkg;

   localparam int TNEW_W_DEF = 3;
   localparam int A_W_DEF    = 5;

   localparam logic [4:0] ZERO_REG = 5'd0;

   localparam int STAGE_D_DEC   = 0;
   localparam int STAGE_EMW_DEC = 1;

   typedef enum logic [1:0] {
      LD_HOLD,
      LD_BUBBLE,
      LD_ENTRY
   } load_e;

   // Reset is applied separately by the register process, so it is not an input here.
   function automatic load_e load_sel(input logic flush, input logic en, input logic in_valid);
      load_e sel;
      if (flush)         sel = LD_BUBBLE;
      else if (!en)      sel = LD_HOLD;
      else if (in_valid) sel = LD_ENTRY;
      else               sel = LD_BUBBLE;
      return sel;
   endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous active-high reset; it sticks at all-ones.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc && (cnt_q != '1)) cnt_d = cnt_q + W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register: payload plus A3/Tnew hazard tags, valid bit,
// flush-over-stall priority, saturating Tnew decrement and hazard debug counters.
module pipe_stage_reg
   import pipe_stage_reg_pkg::*;
#(
   parameter int DATA_W   = 96,
   parameter int A_W      = A_W_DEF,
   parameter int TNEW_W   = TNEW_W_DEF,
   parameter int TNEW_DEC = STAGE_EMW_DEC,
   parameter int CNT_W    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              flush,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_payload,
   input  logic [A_W-1:0]    in_a3,
   input  logic [TNEW_W-1:0] in_tnew,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_payload,
   output logic [A_W-1:0]    out_a3,
   output logic [TNEW_W-1:0] out_tnew,
   output logic              fwd_ready,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   // Compared one bit wider so a decrement larger than the field cannot alias.
   localparam logic [TNEW_W:0] DEC_EXT = (TNEW_W + 1)'(TNEW_DEC);

   load_e             load;
   logic              valid_q,   valid_d;
   logic [DATA_W-1:0] payload_q, payload_d;
   logic [A_W-1:0]    a3_q,      a3_d;
   logic [TNEW_W-1:0] tnew_q,    tnew_d;
   logic [TNEW_W:0]   tnew_ext;
   logic [TNEW_W-1:0] tnew_dec;
   logic              stall_inc;
   logic              flush_inc;

   assign tnew_ext = {1'b0, in_tnew};
   assign tnew_dec = (tnew_ext > DEC_EXT) ? TNEW_W'(tnew_ext - DEC_EXT) : '0;

   always_comb begin
      // NOTE: every next-state signal gets a default before the case, so no path leaves it unassigned and no latch is inferred.
      load      = load_sel(flush, en, in_valid);
      valid_d   = valid_q;
      payload_d = payload_q;
      a3_d      = a3_q;
      tnew_d    = tnew_q;
      unique case (load)
         LD_ENTRY: begin
            valid_d   = 1'b1;
            payload_d = in_payload;
            a3_d      = in_a3;
            tnew_d    = tnew_dec;
         end
         LD_BUBBLE: begin
            valid_d   = 1'b0;
            payload_d = '0;
            a3_d      = A_W'(ZERO_REG);
            tnew_d    = '0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: state is written with non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         valid_q   <= 1'b0;
         payload_q <= '0;
         a3_q      <= A_W'(ZERO_REG);
         tnew_q    <= '0;
      end else begin
         valid_q   <= valid_d;
         payload_q <= payload_d;
         a3_q      <= a3_d;
         tnew_q    <= tnew_d;
      end
   end

   // A stalled bubble is not counted; a flush always wins over the stall.
   assign stall_inc = !flush && !en && valid_q;
   assign flush_inc = flush && in_valid;

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk (clk),
      .rst (rst),
      .inc (stall_inc),
      .cnt (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk (clk),
      .rst (rst),
      .inc (flush_inc),
      .cnt (flush_cnt)
   );

   assign out_valid   = valid_q;
   assign out_payload = payload_q;
   assign out_a3      = a3_q;
   assign out_tnew    = tnew_q;
   assign fwd_ready   = valid_q && (a3_q != A_W'(ZERO_REG)) && (tnew_q == '0);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: default E/M/W instance plus a D-stage (TNEW_DEC=0)
// instance and a 3-bit-counter instance sharing the same stimulus.
module tb_pipe_stage_reg;

   logic        clk;
   logic        rst;
   logic        en;
   logic        flush;
   logic        in_valid;
   logic [95:0] in_payload;
   logic [4:0]  in_a3;
   logic [2:0]  in_tnew;

   logic        out_valid,   out_valid_d,   out_valid_s;
   logic [95:0] out_payload, out_payload_d, out_payload_s;
   logic [4:0]  out_a3,      out_a3_d,      out_a3_s;
   logic [2:0]  out_tnew,    out_tnew_d,    out_tnew_s;
   logic        fwd_ready,   fwd_ready_d,   fwd_ready_s;
   logic [15:0] stall_cnt,   stall_cnt_d;
   logic [15:0] flush_cnt,   flush_cnt_d;
   logic [2:0]  stall_cnt_s, flush_cnt_s;

   int tests = 0;
   int fails = 0;

   typedef struct {
      string       name;
      logic        v;
      logic [95:0] pl;
      logic [4:0]  a3;
      logic [2:0]  tn;
      logic        fwd;
      logic [15:0] st;
      logic [15:0] fl;
      logic [2:0]  dtn;
   } exp_t;

   exp_t exp_q[$];

   pipe_stage_reg dut (
      .clk(clk), .rst(rst), .en(en), .flush(flush), .in_valid(in_valid),
      .in_payload(in_payload), .in_a3(in_a3), .in_tnew(in_tnew),
      .out_valid(out_valid), .out_payload(out_payload), .out_a3(out_a3),
      .out_tnew(out_tnew), .fwd_ready(fwd_ready),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   pipe_stage_reg #(.TNEW_DEC(0)) dut_d (
      .clk(clk), .rst(rst), .en(en), .flush(flush), .in_valid(in_valid),
      .in_payload(in_payload), .in_a3(in_a3), .in_tnew(in_tnew),
      .out_valid(out_valid_d), .out_payload(out_payload_d), .out_a3(out_a3_d),
      .out_tnew(out_tnew_d), .fwd_ready(fwd_ready_d),
      .stall_cnt(stall_cnt_d), .flush_cnt(flush_cnt_d)
   );

   pipe_stage_reg #(.CNT_W(3)) dut_s (
      .clk(clk), .rst(rst), .en(en), .flush(flush), .in_valid(in_valid),
      .in_payload(in_payload), .in_a3(in_a3), .in_tnew(in_tnew),
      .out_valid(out_valid_s), .out_payload(out_payload_s), .out_a3(out_a3_s),
      .out_tnew(out_tnew_s), .fwd_ready(fwd_ready_s),
      .stall_cnt(stall_cnt_s), .flush_cnt(flush_cnt_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input string field,
                        input logic [95:0] act, input logic [95:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", nm, field, act, exp);
      end
   endtask

   // One clock of stimulus; the expected post-edge state is queued for the monitor.
   task automatic step(input string nm,
                       input logic r, input logic e, input logic f, input logic iv,
                       input logic [95:0] pl, input logic [4:0] a3, input logic [2:0] tn,
                       input logic xv, input logic [95:0] xpl, input logic [4:0] xa3,
                       input logic [2:0] xtn, input logic xfwd, input int xst,
                       input int xfl, input logic [2:0] xdtn);
      exp_t x;
      rst        = r;
      en         = e;
      flush      = f;
      in_valid   = iv;
      in_payload = pl;
      in_a3      = a3;
      in_tnew    = tn;
      @(posedge clk);
      x.name = nm;
      x.v    = xv;
      x.pl   = xpl;
      x.a3   = xa3;
      x.tn   = xtn;
      x.fwd  = xfwd;
      x.st   = 16'(xst);
      x.fl   = 16'(xfl);
      x.dtn  = xdtn;
      exp_q.push_back(x);
      #1;
   endtask

   // Monitor: compares whenever an expectation is pending, on the falling edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(e.name, "valid",     96'(out_valid),   96'(e.v));
            check(e.name, "payload",   out_payload,      e.pl);
            check(e.name, "a3",        96'(out_a3),      96'(e.a3));
            check(e.name, "tnew",      96'(out_tnew),    96'(e.tn));
            check(e.name, "fwd_ready", 96'(fwd_ready),   96'(e.fwd));
            check(e.name, "stall_cnt", 96'(stall_cnt),   96'(e.st));
            check(e.name, "flush_cnt", 96'(flush_cnt),   96'(e.fl));
            check(e.name, "d_tnew",    96'(out_tnew_d),  96'(e.dtn));
            check(e.name, "c3_stall",  96'(stall_cnt_s), 96'((e.st > 16'd7) ? 16'd7 : e.st));
         end
      end
   end

   initial begin
      // Reset with random inputs.
      for (int i = 0; i < 2; i++)
         step("reset", 1'b1, 1'($urandom), 1'($urandom), 1'($urandom),
              {$urandom, $urandom, $urandom}, 5'($urandom), 3'($urandom),
              1'b0, 96'h0, 5'd0, 3'd0, 1'b0, 0, 0, 3'd0);

      // Loads and Tnew decrement / saturation.
      step("load_abc", 0, 1, 0, 1, 96'hABC, 5'd8, 3'd2, 1, 96'hABC, 5'd8, 3'd1, 0, 0, 0, 3'd2);
      step("tnew_sat", 0, 1, 0, 1, 96'h123, 5'd4, 3'd0, 1, 96'h123, 5'd4, 3'd0, 1, 0, 0, 3'd0);
      step("a3_zero",  0, 1, 0, 1, 96'h55,  5'd0, 3'd0, 1, 96'h55,  5'd0, 3'd0, 0, 0, 0, 3'd0);
      step("tnew_max", 0, 1, 0, 1, 96'h777, 5'd7, 3'd3, 1, 96'h777, 5'd7, 3'd2, 0, 0, 0, 3'd3);
      step("tnew_one", 0, 1, 0, 1, 96'h999, 5'd9, 3'd1, 1, 96'h999, 5'd9, 3'd0, 1, 0, 0, 3'd1);

      // Stall: outputs frozen, stall_cnt counts, inputs keep changing.
      for (int k = 1; k <= 5; k++)
         step("stall", 0, 0, 0, 1, 96'(k * 17), 5'(k), 3'(k),
              1, 96'h999, 5'd9, 3'd0, 1, k, 0, 3'd1);
      step("bubble",   0, 1, 0, 0, 96'hDEAD, 5'd3, 3'd2, 0, 96'h0, 5'd0, 3'd0, 0, 5, 0, 3'd0);

      // Flush beats stall; flush of a non-valid input does not count.
      step("load_f00",   0, 1, 0, 1, 96'hF00, 5'd12, 3'd4, 1, 96'hF00, 5'd12, 3'd3, 0, 5, 0, 3'd4);
      step("flush_prio", 0, 0, 1, 1, 96'hBAD, 5'd6,  3'd0, 0, 96'h0,   5'd0,  3'd0, 0, 5, 1, 3'd0);
      step("flush_inv",  0, 1, 1, 0, 96'h1,   5'd1,  3'd1, 0, 96'h0,   5'd0,  3'd0, 0, 5, 1, 3'd0);
      step("stall_bub",  0, 0, 0, 1, 96'h2,   5'd2,  3'd2, 0, 96'h0,   5'd0,  3'd0, 0, 5, 1, 3'd0);

      // Reset in the middle of a stall with flush asserted.
      step("rst_clr",   1, 1, 0, 1, 96'h3,   5'd3, 3'd3, 0, 96'h0,   5'd0, 3'd0, 0, 0, 0, 3'd0);
      step("flush_one", 0, 1, 1, 1, 96'h4,   5'd4, 3'd4, 0, 96'h0,   5'd0, 3'd0, 0, 0, 1, 3'd0);
      step("load_333",  0, 1, 0, 1, 96'h333, 5'd3, 3'd5, 1, 96'h333, 5'd3, 3'd4, 0, 0, 1, 3'd5);
      for (int k = 1; k <= 3; k++)
         step("stall3", 0, 0, 0, 0, 96'(k), 5'(k), 3'(k),
              1, 96'h333, 5'd3, 3'd4, 0, k, 1, 3'd5);
      step("rst_mid",   1, 0, 1, 1, 96'h6,   5'd6, 3'd6, 0, 96'h0,   5'd0, 3'd0, 0, 0, 0, 3'd0);

      // Long stall: 16-bit counter keeps counting, 3-bit copy sticks at 7.
      step("load_5a", 0, 1, 0, 1, 96'h5A, 5'd2, 3'd0, 1, 96'h5A, 5'd2, 3'd0, 1, 0, 0, 3'd0);
      for (int k = 1; k <= 10; k++)
         step("sat", 0, 0, 0, 1, 96'(k), 5'(k), 3'(k),
              1, 96'h5A, 5'd2, 3'd0, 1, k, 0, 3'd0);
      step("final_bub", 0, 1, 0, 0, 96'h0, 5'd0, 3'd0, 0, 96'h0, 5'd0, 3'd0, 0, 10, 0, 3'd0);

      for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clk);
      #1;
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Generic, parametrised pipeline stage register for the 5-stage CPU. It replaces the per-stage D/E/M/W registers with one configurable block. It carries an opaque payload (IR, PC, operands packed by the instantiating stage) plus the hazard tags A3 and Tnew, and adds a valid bit, stall/flush with fixed priority, and a configurable Tnew decrement. It also exposes a forwarding-ready flag and saturating stall/flush performance counters for hazard-unit debug.

Parameters:
DATA_W, 96, payload width in bits (packed stage fields).
A_W, 5, register-address tag width.
TNEW_W, 3, Tnew field width.
TNEW_DEC, 1, amount subtracted from Tnew on load (0 for D stage, 1 for E/M/W).
CNT_W, 16, width of each performance counter.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous, active-high reset.
en  in  1  load enable; 0 = hold (stall).
flush  in  1  insert bubble on this edge.
in_valid  in  1  incoming entry is a real instruction.
in_payload  in  DATA_W  incoming stage fields.
in_a3  in  A_W  incoming destination register.
in_tnew  in  TNEW_W  incoming Tnew.
out_valid  out  1  stored entry valid.
out_payload  out  DATA_W  stored payload.
out_a3  out  A_W  stored destination register.
out_tnew  out  TNEW_W  stored Tnew.
fwd_ready  out  1  combinational: out_valid & (out_a3 != 0) & (out_tnew == 0).
stall_cnt  out  CNT_W  cycles a valid entry was held.
flush_cnt  out  CNT_W  valid incoming entries discarded by flush.

Behaviour:
- All state updates on posedge clk. Priority is rst > flush > en > hold.
- rst=1: out_valid, out_payload, out_a3, out_tnew, stall_cnt, flush_cnt all load 0. Power-up (initial) values are also 0.
- flush=1 (rst=0): load a bubble. out_valid=0, out_payload=0, out_a3=0, out_tnew=0. Flush overrides en=0, so a stalled stage can still be flushed.
- en=1, flush=0, in_valid=1:
  - out_valid=1, out_payload=in_payload, out_a3=in_a3.
  - out_tnew = (in_tnew > TNEW_DEC) ? in_tnew - TNEW_DEC : 0. This saturates at 0 and never wraps.
- en=1, flush=0, in_valid=0: load a bubble, with the same values as flush (a3 forced to 0 so the hazard unit sees no producer).
- en=0, flush=0: every output field holds. Tnew does not decrement while held.
- Latency: 1 cycle from inputs to outputs. fwd_ready is purely combinational from the registered fields.
- A3 = 0 is never reported as a producer, regardless of Tnew.
- stall_cnt increments by 1 when rst=0, flush=0, en=0 and out_valid=1; it saturates at all-ones.
- flush_cnt increments by 1 when rst=0, flush=1 and in_valid=1; it saturates at all-ones.
- Counters change only through these rules or reset. There is no wrap-around.
- Reset mid-stall or mid-flush: rst wins; all state is 0 on the following cycle.
- Simultaneous flush & en=0 with out_valid=1: the bubble loads, stall_cnt does not increment, and flush_cnt increments only if in_valid=1.

Decomposition:
- Shared package/`include (const.v): default TNEW_W, A_W, the ZERO_REG constant (5'd0), and per-stage TNEW_DEC values (STAGE_D_DEC=0, STAGE_EMW_DEC=1).
- One natural sub-module, sat_counter (parameter W; ports clk, rst, inc, cnt). It is instantiated twice for stall_cnt and flush_cnt.

Test Plan:
- Reset: drive rst=1 for 2 cycles with random inputs -> all outputs 0, fwd_ready=0; release, en=1, in_valid=1, in_a3=8, in_tnew=2, payload=0xABC -> next cycle out_valid=1, out_a3=8, out_tnew=1, payload=0xABC, fwd_ready=0.
- Tnew saturation (TNEW_DEC=1): in_tnew=0 -> out_tnew=0, fwd_ready=1 for in_a3=4; in_a3=0, in_tnew=0 -> fwd_ready=0. With TNEW_DEC=0, in_tnew=3 -> out_tnew=3.
- Stall: load a valid entry, then en=0 for 5 cycles with changing inputs -> outputs frozen, out_tnew unchanged, stall_cnt=5; en=1 with in_valid=0 -> bubble, stall_cnt stays 5.
- Flush priority: en=0, flush=1, in_valid=1 while out_valid=1 -> next cycle all outputs 0, flush_cnt=1, stall_cnt unchanged.
- Saturation: CNT_W=3, hold a valid entry with en=0 for 10 cycles -> stall_cnt reaches 7 and stays 7.
- Reset mid-stall: stall_cnt=3 with an entry held, assert rst for one cycle with en=0, flush=1 -> all outputs and both counters 0 on the next cycle.
